// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the commit-point trap controller.
package trap_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } trap_state_t;

  localparam logic [31:0] CAUSE_M_TIMER_IRQ   = 32'h8000_0007;
  localparam logic [1:0]  PRIV_M              = 2'd3;
  localparam logic [1:0]  PRIV_U              = 2'd0;
  localparam logic [1:0]  MTVEC_MODE_VECTORED = 2'd1;

  function automatic logic [31:0] mtvec_base(input logic [31:0] mtvec);
    return {mtvec[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/trap_arbiter.sv
// Combinational priority between timer interrupt, exception and mret, plus trap data and
// target select. Vectored interrupt targets are built only with TRAP_VECTORED_EN defined.
module trap_arbiter
  import trap_ctrl_pkg::*;
(
  input  logic        enable,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_tval,
  input  logic        mret_req,
  input  logic        timer_interrupt,
  input  logic        mie_mtie,
  input  logic        mstatus_mie,
  input  logic [1:0]  priv_mode,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] mepc_in,
  output logic        trap_take,
  output logic        mret_take,
  output logic [31:0] cause,
  output logic [31:0] tpc,
  output logic [31:0] tval,
  output logic [31:0] target
);

  logic irq_pend;
  logic irq_sel;

  // Lower privilege than M always takes the interrupt regardless of mstatus.MIE.
  assign irq_pend = timer_interrupt & mie_mtie & (mstatus_mie | (priv_mode != PRIV_M));

  always_comb begin
    trap_take = 1'b0;
    mret_take = 1'b0;
    irq_sel   = 1'b0;
    cause     = '0;
    tpc       = '0;
    tval      = '0;
    if (enable && commit_valid) begin
      if (irq_pend) begin
        trap_take = 1'b1;
        irq_sel   = 1'b1;
        cause     = CAUSE_M_TIMER_IRQ;
        tpc       = commit_pc;
      end else if (exc_valid) begin
        trap_take = 1'b1;
        cause     = {27'b0, exc_code};
        tpc       = commit_pc;
        tval      = exc_tval;
      end else if (mret_req) begin
        mret_take = 1'b1;
      end
    end
  end

`ifdef TRAP_VECTORED_EN
  always_comb begin
    target = mtvec_base(mtvec_in);
    if (mret_take) begin
      target = mepc_in;
    end else if (irq_sel && (mtvec_in[1:0] == MTVEC_MODE_VECTORED)) begin
      target = mtvec_base(mtvec_in) + {25'b0, cause[4:0], 2'b00};
    end
  end
`else
  logic unused_mode;
  assign unused_mode = ^{mtvec_in[1:0], irq_sel};

  always_comb begin
    target = mtvec_base(mtvec_in);
    if (mret_take) begin
      target = mepc_in;
    end
  end
`endif

endmodule

// File: rtl/trap_ctrl.sv
// Commit-point trap controller: raises CSR trap/mret pulses, then flushes and redirects fetch.
// Optional macro TRAP_VECTORED_EN enables vectored interrupt targets.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_tval,
  input  logic        mret_req,
  input  logic        timer_interrupt,
  input  logic        mie_mtie,
  input  logic        mstatus_mie,
  input  logic [1:0]  priv_mode,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] mepc_in,
  output logic        trap_enter,
  output logic [31:0] trap_cause,
  output logic [31:0] trap_pc,
  output logic [31:0] trap_val,
  output logic        mret_exec,
  output logic        flush,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  localparam logic [3:0] CntInit = 4'(FLUSH_CYCLES - 1);

  trap_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] target_q, target_d;

  logic        arb_enable;
  logic        trap_take;
  logic        mret_take;
  logic [31:0] arb_cause;
  logic [31:0] arb_tpc;
  logic [31:0] arb_tval;
  logic [31:0] arb_target;

  // Gating with rst keeps the CSR pulses quiet during the reset cycle.
  assign arb_enable = (state_q == IDLE) & ~rst;

  trap_arbiter u_arbiter (
    .enable          (arb_enable),
    .commit_valid    (commit_valid),
    .commit_pc       (commit_pc),
    .exc_valid       (exc_valid),
    .exc_code        (exc_code),
    .exc_tval        (exc_tval),
    .mret_req        (mret_req),
    .timer_interrupt (timer_interrupt),
    .mie_mtie        (mie_mtie),
    .mstatus_mie     (mstatus_mie),
    .priv_mode       (priv_mode),
    .mtvec_in        (mtvec_in),
    .mepc_in         (mepc_in),
    .trap_take       (trap_take),
    .mret_take       (mret_take),
    .cause           (arb_cause),
    .tpc             (arb_tpc),
    .tval            (arb_tval),
    .target          (arb_target)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    flush    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trap_take || mret_take) begin
          state_d  = FLUSH;
          cnt_d    = CntInit;
          target_d = arb_target;
          flush    = 1'b1;
        end
      end
      FLUSH: begin
        flush = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = REDIRECT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
    end
  end

  assign trap_enter     = trap_take;
  assign trap_cause     = arb_cause;
  assign trap_pc        = arb_tpc;
  assign trap_val       = arb_tval;
  assign mret_exec      = mret_take;
  assign busy           = (state_q != IDLE);
  assign redirect_valid = (state_q == REDIRECT);
  assign redirect_pc    = redirect_valid ? target_q : 32'h0;

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Initiator side of the CSR trap interface; sits at the pipeline commit point (MEM/WB boundary).
- Arbitrates synchronous exceptions, the machine timer interrupt and mret for the committing instruction.
- Drives the trap_enter/trap_cause/trap_pc/trap_val and mret_exec pulses into the CSR register file.
- Sequences pipeline flush and redirect to mtvec or mepc.

Parameters:
FLUSH_CYCLES, 2, cycles flush is held after an event (legal range 1..15)

Ports:
clk  input  1  core clock
rst  input  1  reset; synchronous, active-high
commit_valid  input  1  instruction present at commit point this cycle
commit_pc  input  32  PC of committing instruction
exc_valid  input  1  committing instruction raised a synchronous exception
exc_code  input  5  exception code (mcause[4:0])
exc_tval  input  32  faulting address/instruction for mtval
mret_req  input  1  committing instruction is mret
timer_interrupt  input  1  machine timer pending (level)
mie_mtie  input  1  mie.MTIE from CSR file
mstatus_mie  input  1  mstatus.MIE from CSR file
priv_mode  input  2  current privilege (0=U, 3=M)
mtvec_in  input  32  mtvec from CSR file
mepc_in  input  32  mepc from CSR file
trap_enter  output  1  one-cycle pulse to CSR file
trap_cause  output  32  mcause value, valid with trap_enter
trap_pc  output  32  mepc value, valid with trap_enter
trap_val  output  32  mtval value, valid with trap_enter
mret_exec  output  1  one-cycle pulse to CSR file
flush  output  1  squash all in-flight younger instructions
busy  output  1  state != IDLE; front end stalls fetch
redirect_valid  output  1  redirect PC offered to fetch
redirect_pc  output  32  new fetch PC
redirect_ready  input  1  fetch accepts redirect

Behaviour:
- Reset (synchronous): state IDLE, counter 0, all outputs 0, including redirect_pc and trap_* data.
- irq_take = timer_interrupt & mie_mtie & (mstatus_mie | priv_mode != 3). Evaluated only in IDLE with commit_valid=1.
- Priority in IDLE when commit_valid=1:
  - irq_take: interrupt. Cause 32'h8000_0007; trap_pc = commit_pc (instruction squashed, not retired); trap_val = 0.
  - Else exc_valid: exception. Cause {27'b0, exc_code}; trap_pc = commit_pc; trap_val = exc_tval.
  - Else mret_req: mret.
  - Else nothing; stay IDLE.
- trap_enter/mret_exec and the trap_* data are combinational from the IDLE inputs. They are asserted in the event cycle only, for exactly one cycle; trap_* data are 0 when trap_enter=0.
- Target latch in the event cycle:
  - Trap: target = {mtvec_in[31:2],2'b00}.
  - mret: target = mepc_in, sampled before the CSR file updates.
- FSM:
  - IDLE: on event -> FLUSH, counter = FLUSH_CYCLES-1; flush=1 in the event cycle.
  - FLUSH: flush=1, busy=1. Counter decrements; at 0 -> REDIRECT.
  - REDIRECT: flush=0, redirect_valid=1, redirect_pc=target held stable. On redirect_ready -> IDLE.
- Total: flush is high for FLUSH_CYCLES+1 cycles (event cycle plus FLUSH_CYCLES). Earliest redirect handshake is FLUSH_CYCLES+1 cycles after the event.
- All events are ignored outside IDLE (commit_valid, exc_valid, mret_req, timer); no pulses are generated.
- A timer interrupt that arrives while busy is taken at the first IDLE cycle with commit_valid=1, if still pending and enabled.
- exc_valid and mret_req together: exception wins; mret is not executed.
- commit_valid=0 in IDLE: no event, even with a pending interrupt.
- Reset in any state returns to IDLE next edge; a pending redirect is dropped.

Optional Feature:
TRAP_VECTORED_EN
- Defined: mtvec_in[1:0]==1 with an interrupt gives target = {mtvec_in[31:2],2'b00} + 4*cause[4:0], which is +28 for timer. Exceptions always use base.
- Undefined: mode bits ignored; all traps use base.

Decomposition:
- Shared package holds:
  - State enum trap_state_t {IDLE, FLUSH, REDIRECT}.
  - Constants CAUSE_M_TIMER_IRQ=32'h8000_0007, PRIV_M=2'd3, PRIV_U=2'd0, MTVEC_MODE_VECTORED=2'd1.
- One natural sub-module, trap_arbiter: combinational priority, cause/pc/tval and target select.

Test Plan:
- Exception: commit_valid=1, exc_valid=1, exc_code=2, commit_pc=0x8000_0100, exc_tval=0xDEAD_BEEF, mtvec_in=0x8000_0004 -> trap_enter pulse with cause 0x2, trap_pc 0x8000_0100, trap_val 0xDEAD_BEEF. flush high 3 cycles. redirect_pc=0x8000_0004 offered until redirect_ready.
- Timer: timer_interrupt=1, mie_mtie=1, mstatus_mie=1, priv_mode=3, exc_valid=1 same cycle -> cause 0x8000_0007, trap_val 0. With TRAP_VECTORED_EN and mtvec_in=0x8000_0001 -> redirect_pc 0x8000_001C.
- Masking: mstatus_mie=0, priv_mode=3 -> no trap. Same with priv_mode=0 -> interrupt taken.
- mret: mret_req=1, mepc_in=0x8000_0200 -> mret_exec pulse, no trap_enter, redirect_pc 0x8000_0200.
- Backpressure: hold redirect_ready=0 for 5 cycles while driving exc_valid -> redirect_valid and redirect_pc stable, no new pulses, handshake on ready.
- Reset asserted in FLUSH -> next cycle IDLE, all outputs 0. New exception afterwards is handled normally.
